// File: rtl/univ_shift_reg_pkg.sv
// Shared encodings for the universal shift register: op modes, burst FSM states, mode classification.
// Pure declarations; no timing or flow-control behaviour of its own.
package univ_shift_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_SHL  = 3'd1;
   localparam logic [2:0] MODE_SHR  = 3'd2;
   localparam logic [2:0] MODE_ASR  = 3'd3;
   localparam logic [2:0] MODE_ROL  = 3'd4;
   localparam logic [2:0] MODE_ROR  = 3'd5;
   localparam logic [2:0] MODE_LOAD = 3'd6;
   localparam logic [2:0] MODE_RSVD = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Only the shift/rotate modes make sense repeated, so only they may start a burst.
   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m >= MODE_SHL) && (m <= MODE_ROR);
   endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of univ_shift_reg; the master drives ops, the slave returns contents and status.
// No latency of its own; burst status (busy/done) stands in for a ready signal.
interface univ_shift_reg_if #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
);
   logic             en;
   logic             clr;
   logic [2:0]       mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic             start;
   logic [AMT_W-1:0] amount;
   logic [WIDTH-1:0] q;
   logic             sout_l;
   logic             sout_r;
   logic             busy;
   logic             done;

   modport master (
      output en, clr, mode, d, sin_l, sin_r, start, amount,
      input  q, sout_l, sout_r, busy, done
   );

   modport slave (
      input  en, clr, mode, d, sin_l, sin_r, start, amount,
      output q, sout_l, sout_r, busy, done
   );
endinterface

// File: rtl/univ_shift_reg_shift_step.sv
// One step of the universal register: next word from current word, mode and serial inputs.
// Purely combinational; no flow control.
module shift_step
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  logic [2:0]       mode,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] nxt
);

   always_comb begin
      nxt = q;
      case (mode)
         MODE_SHL:             nxt = {q[WIDTH-2:0], sin_r};
         MODE_SHR:             nxt = {sin_l, q[WIDTH-1:1]};
         MODE_ASR:             nxt = {q[WIDTH-1], q[WIDTH-1:1]};
         MODE_ROL:             nxt = {q[WIDTH-2:0], q[WIDTH-1]};
         MODE_ROR:             nxt = {q[0], q[WIDTH-1:1]};
         MODE_LOAD:            nxt = d;
         MODE_HOLD, MODE_RSVD: nxt = q;
         default:              nxt = q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and counted bursts (busy/done handshake).
// Result 1 cycle after the edge; en=0 stalls direct ops and burst steps, clr/start are not gated.
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   univ_shift_reg_if.slave  bus
);

   state_t           state, state_nxt;
   logic [AMT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bmode, bmode_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic [WIDTH-1:0] step_q;
   logic [2:0]       step_mode;

   // While bursting, the latched mode drives the step; live mode is ignored.
   assign step_mode = (state == ST_BUSY) ? bmode : bus.mode;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .q     (q_r),
      .mode  (step_mode),
      .sin_l (bus.sin_l),
      .sin_r (bus.sin_r),
      .d     (bus.d),
      .nxt   (step_q)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         bmode <= MODE_HOLD;
         q_r   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         bmode <= bmode_nxt;
         q_r   <= q_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bmode_nxt = bmode;
      q_nxt     = q_r;
      if (bus.clr) begin
         state_nxt = ST_IDLE;
         cnt_nxt   = '0;
         q_nxt     = '0;
      end else if (state == ST_BUSY) begin
         if (bus.en) begin
            q_nxt   = step_q;
            cnt_nxt = cnt - AMT_W'(1);
            if (cnt == AMT_W'(1))
               state_nxt = ST_DONE;
         end
      end else begin
         // DONE lasts one cycle, then behaves exactly like IDLE.
         state_nxt = ST_IDLE;
         if (bus.start && is_burst_mode(bus.mode)) begin
            bmode_nxt = bus.mode;
            cnt_nxt   = bus.amount;
            state_nxt = (bus.amount == '0) ? ST_DONE : ST_BUSY;
         end else if (bus.en) begin
            q_nxt = step_q;
         end
      end
   end

   assign bus.q      = q_r;
   assign bus.sout_l = q_r[WIDTH-1];
   assign bus.sout_r = q_r[0];
   assign bus.busy   = (state == ST_BUSY);
   assign bus.done   = (state == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: expected values queued at stimulus time, popped at each observation.
module tb_univ_shift_reg;
   import univ_shift_reg_pkg::*;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   logic [31:0] sb[$];

   univ_shift_reg_if #(.WIDTH(8), .AMT_W(4)) bus ();

   univ_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic want(input logic [31:0] v);
      sb.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL %s: observed 0x%0h, scoreboard empty", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         end
      end
   endtask

   // Counts further busy cycles until the burst ends; bounded so a stuck FSM cannot hang.
   task automatic drain(input int n0, output int n);
      n = n0;
      for (int i = 0; i < 64 && bus.busy; i++) begin
         tick();
         if (bus.busy) n++;
      end
   endtask

   task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] dv);
      bus.en   = e;
      bus.mode = m;
      bus.d    = dv;
   endtask

   initial begin
      int n;
      reset = 1'b0;
      bus.en = 0; bus.clr = 0; bus.mode = MODE_HOLD; bus.d = 0;
      bus.sin_l = 0; bus.sin_r = 0; bus.start = 0; bus.amount = 0;
      tick(); tick();
      want(0); chk("reset_q", {24'd0, bus.q});
      want(0); chk("reset_busy", {31'd0, bus.busy});
      want(0); chk("reset_done", {31'd0, bus.done});
      reset = 1'b1;
      tick();

      // Asynchronous reset mid-burst
      drive(1, MODE_LOAD, 8'h5A); tick();
      bus.start = 1; bus.mode = MODE_ROL; bus.amount = 4'd5; tick();
      bus.start = 0; bus.en = 0;
      want(8'h5A); chk("pre_reset_q", {24'd0, bus.q});
      want(1);     chk("pre_reset_busy", {31'd0, bus.busy});
      #2 reset = 1'b0;
      #1;
      want(0); chk("async_reset_q", {24'd0, bus.q});
      want(0); chk("async_reset_busy", {31'd0, bus.busy});
      want(0); chk("async_reset_done", {31'd0, bus.done});
      #1 reset = 1'b1;
      drive(0, MODE_HOLD, 8'h00);
      tick();

      // Direct ops
      drive(1, MODE_LOAD, 8'hA5); tick();
      want(8'hA5); chk("load_a5", {24'd0, bus.q});
      bus.mode = MODE_SHL; bus.sin_r = 1; tick();
      want(8'h4B); chk("shl_sin1", {24'd0, bus.q});
      bus.en = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         want(8'h4B); chk("en0_hold", {24'd0, bus.q});
      end

      // Arithmetic shift and rotate
      drive(1, MODE_LOAD, 8'h96); tick();
      bus.mode = MODE_ASR; tick();
      want(8'hCB); chk("asr", {24'd0, bus.q});
      want(1);     chk("asr_sout_l", {31'd0, bus.sout_l});
      want(1);     chk("asr_sout_r", {31'd0, bus.sout_r});
      bus.mode = MODE_ROR; tick();
      want(8'hE5); chk("ror", {24'd0, bus.q});
      bus.mode = MODE_SHR; bus.sin_l = 0; tick();
      want(8'h72); chk("shr_sin0", {24'd0, bus.q});

      // Burst ROL x3
      drive(1, MODE_LOAD, 8'h01); tick();
      bus.start = 1; bus.mode = MODE_ROL; bus.amount = 4'd3; tick();
      bus.start = 0; bus.mode = MODE_HOLD;
      want(8'h01); chk("burst_start_noshift", {24'd0, bus.q});
      drain(1, n);
      want(3);     chk("burst_busy_cycles", n);
      want(8'h08); chk("burst_q", {24'd0, bus.q});
      want(1);     chk("burst_done", {31'd0, bus.done});
      tick();
      want(0);     chk("burst_done_1cyc", {31'd0, bus.done});

      // Burst with one stalled cycle
      drive(1, MODE_LOAD, 8'h01); tick();
      bus.start = 1; bus.mode = MODE_ROL; bus.amount = 4'd3; tick();
      bus.start = 0; bus.mode = MODE_HOLD; bus.en = 0;
      tick();
      bus.en = 1;
      drain(2, n);
      want(4);     chk("stall_busy_cycles", n);
      want(8'h08); chk("stall_q", {24'd0, bus.q});
      want(1);     chk("stall_done", {31'd0, bus.done});
      tick();

      // Zero-length burst
      bus.start = 1; bus.mode = MODE_SHL; bus.amount = 4'd0; tick();
      bus.start = 0; bus.en = 0; bus.mode = MODE_HOLD;
      want(1);     chk("zero_done", {31'd0, bus.done});
      want(0);     chk("zero_busy", {31'd0, bus.busy});
      want(8'h08); chk("zero_q", {24'd0, bus.q});
      tick();
      want(0);     chk("zero_done_drop", {31'd0, bus.done});
      want(0);     chk("zero_busy_after", {31'd0, bus.busy});

      // Oversize burst saturates to the fill value
      drive(1, MODE_LOAD, 8'hFF); tick();
      bus.start = 1; bus.mode = MODE_SHL; bus.sin_r = 0; bus.amount = 4'd12; tick();
      bus.start = 0; bus.mode = MODE_HOLD;
      drain(1, n);
      want(12);    chk("big_busy_cycles", n);
      want(8'h00); chk("big_q", {24'd0, bus.q});
      want(1);     chk("big_done", {31'd0, bus.done});
      tick();

      // clr aborts a burst on its second step
      drive(1, MODE_LOAD, 8'h81); tick();
      bus.start = 1; bus.mode = MODE_ROL; bus.amount = 4'd5; tick();
      bus.start = 0; bus.mode = MODE_HOLD;
      tick();
      want(8'h03); chk("abort_step1", {24'd0, bus.q});
      bus.clr = 1; tick();
      bus.clr = 0;
      want(8'h00); chk("abort_q", {24'd0, bus.q});
      want(0);     chk("abort_busy", {31'd0, bus.busy});
      want(0);     chk("abort_done", {31'd0, bus.done});
      tick();
      want(0);     chk("abort_no_done", {31'd0, bus.done});

      // start while busy must not restart or re-count
      drive(1, MODE_LOAD, 8'h01); tick();
      bus.start = 1; bus.mode = MODE_ROL; bus.amount = 4'd3; tick();
      bus.mode = MODE_SHL; bus.amount = 4'd7; tick();
      bus.start = 0; bus.mode = MODE_HOLD;
      drain(2, n);
      want(3);     chk("busy_start_cycles", n);
      want(8'h08); chk("busy_start_q", {24'd0, bus.q});
      want(1);     chk("busy_start_done", {31'd0, bus.done});
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
